// File: rtl/deinterleave_block_output.sv
// Reassembles time-interleaved per-set sample blocks into contiguous serial output blocks.
// Define DEINTERLEAVE_ERR_FLAGS_EN to add the err_overflow / err_orphan pulse outputs.

module deinterleave_block_output #(
   parameter int unsigned BITS = 8,
   parameter int unsigned IIR  = 3,
   parameter int unsigned N    = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_block_start,
   input  logic [$clog2(IIR)-1:0] in_set,
   input  logic [BITS-1:0]        data_in,
   output logic                   out_valid,
   output logic                   block_start,
`ifdef DEINTERLEAVE_ERR_FLAGS_EN
   output logic [BITS-1:0]        data_out,
   output logic                   err_overflow,
   output logic                   err_orphan
`else
   output logic [BITS-1:0]        data_out
`endif
);

   localparam int unsigned SW  = $clog2(IIR);
   localparam int unsigned SW1 = SW + 1;
   localparam int unsigned RW  = $clog2(N);
   localparam int unsigned CW  = RW + 1;
   localparam int unsigned FCW = $clog2(IIR + 1);

   typedef enum logic [1:0] {
      SET_EMPTY,
      SET_FILLING,
      SET_FULL,
      SET_DRAINING
   } set_state_e;

   typedef enum logic {
      OUT_IDLE,
      OUT_DRAIN
   } out_state_e;

   set_state_e       set_st_q  [IIR];
   logic [CW-1:0]    wr_cnt_q  [IIR];
   logic [BITS-1:0]  mem_q     [IIR][N];
   logic [SW-1:0]    fifo_q    [IIR];
   logic [SW-1:0]    fifo_rd_q;
   logic [SW-1:0]    fifo_wr_q;
   logic [FCW-1:0]   fifo_cnt_q;
   out_state_e       out_st_q;
   logic [SW-1:0]    cur_set_q;
   logic [RW-1:0]    rd_cnt_q;
   logic             out_valid_q;
   logic             block_start_q;
   logic [BITS-1:0]  data_out_q;

   logic             beat_ok;
   logic [SW-1:0]    sel_set;
   set_state_e       in_st;
   logic [CW-1:0]    in_cnt;
   logic [RW-1:0]    wr_idx;
   logic             start_ok;
   logic             data_ok;
   logic             push;
   logic             fifo_ne;
   logic [SW-1:0]    head;
   logic             last_smp;
   logic             pop;
   logic             emit;
   logic [SW-1:0]    emit_set;
   logic [RW-1:0]    emit_idx;

   always_comb begin
      beat_ok  = in_valid && ({1'b0, in_set} < SW1'(IIR));
      sel_set  = beat_ok ? in_set : '0;
      in_st    = set_st_q[sel_set];
      in_cnt   = wr_cnt_q[sel_set];
      wr_idx   = in_cnt[RW-1:0];
      start_ok = beat_ok && in_block_start &&
                 (in_st == SET_EMPTY || in_st == SET_FILLING);
      data_ok  = beat_ok && !in_block_start && (in_st == SET_FILLING);
      push     = data_ok && (in_cnt == CW'(N - 1));

      fifo_ne  = (fifo_cnt_q != '0);
      head     = fifo_q[fifo_rd_q];
      last_smp = (out_st_q == OUT_DRAIN) && (rd_cnt_q == RW'(N - 1));
      pop      = fifo_ne && ((out_st_q == OUT_IDLE) || last_smp);

      // Popping from IDLE emits sample 0 on the same edge, so the first sample follows completion by one cycle.
      emit     = (out_st_q == OUT_DRAIN) || fifo_ne;
      emit_set = (out_st_q == OUT_DRAIN) ? cur_set_q : head;
      emit_idx = (out_st_q == OUT_DRAIN) ? rd_cnt_q  : '0;
   end

   always_ff @(posedge clk) begin
      if (start_ok) begin
         mem_q[sel_set][0] <= data_in;
      end else if (data_ok) begin
         mem_q[sel_set][wr_idx] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < IIR; i++) begin
            set_st_q[i] <= SET_EMPTY;
            wr_cnt_q[i] <= '0;
         end
         fifo_rd_q     <= '0;
         fifo_wr_q     <= '0;
         fifo_cnt_q    <= '0;
         out_st_q      <= OUT_IDLE;
         cur_set_q     <= '0;
         rd_cnt_q      <= '0;
         out_valid_q   <= 1'b0;
         block_start_q <= 1'b0;
         data_out_q    <= '0;
      end else begin
         // Input side only moves EMPTY/FILLING sets; drain side only FULL/DRAINING, so updates never collide.
         if (start_ok) begin
            set_st_q[sel_set] <= SET_FILLING;
            wr_cnt_q[sel_set] <= CW'(1);
         end else if (data_ok) begin
            wr_cnt_q[sel_set] <= in_cnt + CW'(1);
            if (push) begin
               set_st_q[sel_set] <= SET_FULL;
               fifo_q[fifo_wr_q] <= sel_set;
               fifo_wr_q         <= (fifo_wr_q == SW'(IIR - 1)) ? '0 : fifo_wr_q + SW'(1);
            end
         end

         if (pop) begin
            set_st_q[head] <= SET_DRAINING;
            fifo_rd_q      <= (fifo_rd_q == SW'(IIR - 1)) ? '0 : fifo_rd_q + SW'(1);
         end
         if (last_smp) begin
            set_st_q[cur_set_q] <= SET_EMPTY;
         end
         fifo_cnt_q <= fifo_cnt_q + FCW'(push) - FCW'(pop);

         case (out_st_q)
            OUT_IDLE: begin
               if (fifo_ne) begin
                  cur_set_q <= head;
                  rd_cnt_q  <= RW'(1);
                  out_st_q  <= OUT_DRAIN;
               end
            end
            OUT_DRAIN: begin
               if (last_smp) begin
                  rd_cnt_q <= '0;
                  if (fifo_ne) begin
                     cur_set_q <= head;
                  end else begin
                     out_st_q <= OUT_IDLE;
                  end
               end else begin
                  rd_cnt_q <= rd_cnt_q + RW'(1);
               end
            end
            default: out_st_q <= OUT_IDLE;
         endcase

         out_valid_q   <= emit;
         block_start_q <= emit && (emit_idx == '0);
         data_out_q    <= emit ? mem_q[emit_set][emit_idx] : '0;
      end
   end

   assign out_valid   = out_valid_q;
   assign block_start = block_start_q;
   assign data_out    = data_out_q;

`ifdef DEINTERLEAVE_ERR_FLAGS_EN
   logic ovf_q;
   logic orph_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q  <= 1'b0;
         orph_q <= 1'b0;
      end else begin
         ovf_q  <= beat_ok && in_block_start &&
                   (in_st == SET_FULL || in_st == SET_DRAINING);
         orph_q <= beat_ok && !in_block_start && (in_st != SET_FILLING);
      end
   end

   assign err_overflow = ovf_q;
   assign err_orphan   = orph_q;
`endif

endmodule
